// File: rtl/arm_alu_pipe.sv
// Two-stage ARM data-processing ALU: stage A registers the operation, stage B holds the result.
// The committed NZCV register updates when a flag-setting result is delivered.
module arm_alu_pipe #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_op1,
    input  logic [WIDTH-1:0] in_op2,
    input  logic [3:0]       in_sel,
    input  logic             in_s,
    input  logic             in_shift_c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_wr,
    output logic [3:0]       out_flags,
    output logic [3:0]       flags
);

    logic             r_a_valid;
    logic [WIDTH-1:0] r_a_op1;
    logic [WIDTH-1:0] r_a_op2;
    logic [3:0]       r_a_sel;
    logic             r_a_s;
    logic             r_a_shc;

    logic             r_b_valid;
    logic [WIDTH-1:0] r_b_data;
    logic             r_b_wr;
    logic [3:0]       r_b_flags;
    logic             r_b_upd;
    logic [3:0]       r_flags;

    logic             w_b_adv;
    logic             w_accept;
    logic             w_deliver;
    logic [3:0]       w_fwd;
    logic [WIDTH-1:0] w_x;
    logic [WIDTH-1:0] w_y;
    logic             w_cin;
    logic             w_arith;
    logic [WIDTH-1:0] w_logic;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_res;
    logic             w_c;
    logic             w_v;
    logic [3:0]       w_nzcv;
    logic             w_test;

    assign w_b_adv   = !r_b_valid || out_ready;
    assign in_ready  = !reset && (!r_a_valid || w_b_adv);
    assign w_accept  = in_valid && in_ready;
    assign w_deliver = r_b_valid && out_ready;

    // Carry-in and prior V come from the flags as they stand after this cycle's delivery
    assign w_fwd = (w_deliver && r_b_upd) ? r_b_flags : r_flags;

    always_comb begin
        w_x     = '0;
        w_y     = '0;
        w_cin   = 1'b0;
        w_arith = 1'b1;
        w_logic = '0;
        unique case (r_a_sel)
            4'h0, 4'h8: begin w_arith = 1'b0; w_logic = r_a_op1 & r_a_op2; end
            4'h1, 4'h9: begin w_arith = 1'b0; w_logic = r_a_op1 ^ r_a_op2; end
            4'h2, 4'hA: begin w_x = r_a_op1; w_y = ~r_a_op2; w_cin = 1'b1;     end
            4'h3:       begin w_x = r_a_op2; w_y = ~r_a_op1; w_cin = 1'b1;     end
            4'h4, 4'hB: begin w_x = r_a_op1; w_y = r_a_op2;  w_cin = 1'b0;     end
            4'h5:       begin w_x = r_a_op1; w_y = r_a_op2;  w_cin = w_fwd[1]; end
            4'h6:       begin w_x = r_a_op1; w_y = ~r_a_op2; w_cin = w_fwd[1]; end
            4'h7:       begin w_x = r_a_op2; w_y = ~r_a_op1; w_cin = w_fwd[1]; end
            4'hC:       begin w_arith = 1'b0; w_logic = r_a_op1 | r_a_op2;  end
            4'hD:       begin w_arith = 1'b0; w_logic = r_a_op2;            end
            4'hE:       begin w_arith = 1'b0; w_logic = r_a_op1 & ~r_a_op2; end
            4'hF:       begin w_arith = 1'b0; w_logic = ~r_a_op2;           end
            default:    begin w_arith = 1'b0; end
        endcase
    end

    assign w_sum  = {1'b0, w_x} + {1'b0, w_y} + {{WIDTH{1'b0}}, w_cin};
    assign w_res  = w_arith ? w_sum[WIDTH-1:0] : w_logic;
    assign w_c    = w_arith ? w_sum[WIDTH] : r_a_shc;
    assign w_v    = w_arith ? ((w_x[WIDTH-1] == w_y[WIDTH-1]) &&
                               (w_sum[WIDTH-1] != w_x[WIDTH-1])) : w_fwd[0];
    assign w_nzcv = {w_res[WIDTH-1], (w_res == '0), w_c, w_v};
    assign w_test = (r_a_sel[3:2] == 2'b10);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a_valid <= 1'b0;
            r_a_op1   <= '0;
            r_a_op2   <= '0;
            r_a_sel   <= '0;
            r_a_s     <= 1'b0;
            r_a_shc   <= 1'b0;
            r_b_valid <= 1'b0;
            r_b_data  <= '0;
            r_b_wr    <= 1'b0;
            r_b_flags <= '0;
            r_b_upd   <= 1'b0;
            r_flags   <= '0;
        end else begin
            if (w_deliver && r_b_upd) begin
                r_flags <= r_b_flags;
            end
            if (w_b_adv) begin
                r_b_valid <= r_a_valid;
                if (r_a_valid) begin
                    r_b_data  <= w_res;
                    r_b_wr    <= !w_test;
                    r_b_flags <= w_nzcv;
                    r_b_upd   <= r_a_s || w_test;
                end
            end
            if (w_accept) begin
                r_a_valid <= 1'b1;
                r_a_op1   <= in_op1;
                r_a_op2   <= in_op2;
                r_a_sel   <= in_sel;
                r_a_s     <= in_s;
                r_a_shc   <= in_shift_c;
            end else if (w_b_adv) begin
                r_a_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_b_valid;
    assign out_data  = r_b_data;
    assign out_wr    = r_b_wr;
    assign out_flags = r_b_flags;
    assign flags     = r_flags;

endmodule

// File: tb/tb_arm_alu_pipe.sv
// Directed bench for arm_alu_pipe: a 32-bit instance with an expected-result queue
// checked on every delivery, plus an 8-bit instance for the narrow overflow case.
module tb_arm_alu_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, in_s, in_shift_c;
    logic [31:0] in_op1, in_op2;
    logic [3:0]  in_sel;
    logic        out_valid, out_ready, out_wr;
    logic [31:0] out_data;
    logic [3:0]  out_flags, flags;

    logic        in_valid8, in_ready8, out_valid8, out_wr8;
    logic [7:0]  in_op1_8, in_op2_8, out_data8;
    logic [3:0]  out_flags8, flags8;

    typedef struct packed {
        logic [31:0] d;
        logic        wr;
        logic [3:0]  f;
    } exp_t;

    exp_t exp_q[$];
    int   del_cyc[$];
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    arm_alu_pipe #(.WIDTH(32)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_op1(in_op1), .in_op2(in_op2), .in_sel(in_sel), .in_s(in_s),
        .in_shift_c(in_shift_c), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_wr(out_wr), .out_flags(out_flags), .flags(flags)
    );

    arm_alu_pipe #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
        .in_op1(in_op1_8), .in_op2(in_op2_8), .in_sel(4'h4), .in_s(1'b1),
        .in_shift_c(1'b0), .out_valid(out_valid8), .out_ready(1'b1),
        .out_data(out_data8), .out_wr(out_wr8), .out_flags(out_flags8), .flags(flags8)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Every delivered result must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            exp_t e;
            check_eq("result_pending", 64'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_eq("out_data", out_data, e.d);
                check_eq("out_wr", out_wr, e.wr);
                check_eq("out_flags", out_flags, e.f);
                del_cyc.push_back(cyc);
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] sel,
                        input logic s, input logic shc, input logic push,
                        input logic [31:0] ed, input logic ewr, input logic [3:0] ef);
        logic ok;
        exp_t e;
        ok = 1'b0;
        in_valid = 1'b1; in_op1 = a; in_op2 = b; in_sel = sel; in_s = s; in_shift_c = shc;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        check_eq("accept", ok, 1);
        if (ok && push) begin
            e.d = ed; e.wr = ewr; e.f = ef;
            exp_q.push_back(e);
        end
    endtask

    // Ends on a negedge after the last expected result has been delivered and committed
    task automatic drain();
        in_valid = 1'b0;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        check_eq("drain", exp_q.size(), 0);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic to_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic got8;
        reset = 1'b1; in_valid = 1'b0; in_op1 = '0; in_op2 = '0; in_sel = '0;
        in_s = 1'b0; in_shift_c = 1'b0; out_ready = 1'b1;
        in_valid8 = 1'b0; in_op1_8 = '0; in_op2_8 = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("in_ready_in_reset", in_ready, 0);
        check_eq("in_ready8_in_reset", in_ready8, 0);
        to_edge();
        reset = 1'b0;
        @(negedge clk);
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_flags", flags, 0);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_out_wr", out_wr, 0);
        check_eq("rst_out_flags", out_flags, 0);
        to_edge();

        // Logical/arithmetic mix, no S, back-to-back
        del_cyc.delete();
        send(32, 96, 4'h0, 0, 0, 1, 32'h20,       1, 4'b0000);
        send(32, 96, 4'h1, 0, 0, 1, 32'h40,       1, 4'b0000);
        send(32, 96, 4'h2, 0, 0, 1, 32'hFFFFFFC0, 1, 4'b1000);
        send(32, 96, 4'h3, 0, 0, 1, 32'h40,       1, 4'b0010);
        send(32, 96, 4'hC, 0, 0, 1, 32'h60,       1, 4'b0000);
        send(32, 96, 4'h4, 0, 0, 1, 32'h80,       1, 4'b0000);
        send(32, 96, 4'hE, 0, 0, 1, 32'h00,       1, 4'b0100);
        drain();
        check_eq("stream_count", del_cyc.size(), 7);
        if (del_cyc.size() == 7) check_eq("stream_no_bubble", del_cyc[6] - del_cyc[0], 6);
        check_eq("stream_flags", flags, 4'b0000);
        to_edge();

        // ADDS carry-out forwarded into an immediately following ADC
        send(32'hFFFFFFFF, 1, 4'h4, 1, 0, 1, 32'h0, 1, 4'b0110);
        send(0, 0, 4'h5, 0, 0, 1, 32'h1, 1, 4'b0000);
        drain();
        check_eq("adc_flags", flags, 4'b0110);
        to_edge();

        send(5, 5, 4'hA, 0, 0, 1, 32'h0, 0, 4'b0110);
        drain();
        check_eq("cmp_flags", flags, 4'b0110);
        to_edge();
        send(0, 1, 4'h2, 1, 0, 1, 32'hFFFFFFFF, 1, 4'b1000);
        drain();
        check_eq("subs_flags", flags, 4'b1000);
        to_edge();

        // MOVS takes C from the shifter; TST updates flags even without S
        send(0, 0, 4'hD, 1, 1, 1, 32'h0, 1, 4'b0110);
        send(32'hF0, 32'h0F, 4'h8, 0, 0, 1, 32'h0, 0, 4'b0100);
        drain();
        check_eq("tst_flags", flags, 4'b0100);
        to_edge();

        // Stall: two ops fill the pipe, the third waits
        out_ready = 1'b0;
        send(1, 1, 4'h4, 0, 0, 1, 32'h2, 1, 4'b0000);
        send(2, 2, 4'h4, 0, 0, 1, 32'h4, 1, 4'b0000);
        in_valid = 1'b1; in_op1 = 3; in_op2 = 3; in_sel = 4'h4; in_s = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("stall_in_ready", in_ready, 0);
            check_eq("stall_out_valid", out_valid, 1);
            check_eq("stall_out_data", out_data, 32'h2);
            to_edge();
        end
        out_ready = 1'b1;
        send(3, 3, 4'h4, 0, 0, 1, 32'h6, 1, 4'b0000);
        drain();
        to_edge();

        // Reset with two ops in flight: neither may ever appear
        send(1, 2, 4'h4, 1, 0, 0, 32'h0, 0, 4'b0000);
        send(3, 4, 4'h4, 1, 0, 0, 32'h0, 0, 4'b0000);
        reset = 1'b1;
        in_valid = 1'b0;
        to_edge();
        reset = 1'b0;
        @(negedge clk);
        check_eq("flush_out_valid", out_valid, 0);
        check_eq("flush_flags", flags, 4'b0000);
        repeat (8) @(negedge clk);
        check_eq("flush_quiet", out_valid, 0);
        to_edge();

        // 8-bit signed overflow
        in_valid8 = 1'b1; in_op1_8 = 8'h7F; in_op2_8 = 8'h01;
        to_edge();
        in_valid8 = 1'b0;
        got8 = 1'b0;
        for (int i = 0; i < 10 && !got8; i++) begin
            @(negedge clk);
            got8 = out_valid8;
        end
        check_eq("w8_valid", got8, 1);
        check_eq("w8_data", out_data8, 8'h80);
        check_eq("w8_out_flags", out_flags8, 4'b1001);
        @(negedge clk);
        check_eq("w8_flags", flags8, 4'b1001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
